// File: rtl/ssd_scan_mux_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package ssd_scan_mux_pkg;

  localparam logic [6:0] SSD_BLANK  = 7'h7F;
  localparam logic [7:0] SSD_AN_OFF = 8'hFF;
  localparam logic       SSD_DP_OFF = 1'b1;

  // Entry [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] SSD_DECODE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } ssd_drive_t;

  localparam ssd_drive_t SSD_DRIVE_OFF = '{an: SSD_AN_OFF, seg: SSD_BLANK, dp: SSD_DP_OFF};

endpackage

// File: rtl/ssd_scan_mux_hex_to_ssd.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_ssd
  import ssd_scan_mux_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SSD_DECODE[nibble_i];
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment driver with a frame-synchronous shadow register
// so a new value never appears partway through a scan.
module ssd_scan_mux
  import ssd_scan_mux_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                ssd_scan_clk,
  input  logic                ssd_scan_rst,
  input  logic [4*DIGITS-1:0] ssd_scan_value,
  input  logic                ssd_scan_load,
  input  logic                ssd_scan_en,
  input  logic [DIGITS-1:0]   ssd_scan_dp_mask,
  output logic [6:0]          ssd_scan_seg,
  output logic                ssd_scan_dp,
  output logic [7:0]          ssd_scan_an,
  output logic                ssd_scan_frame
);

  localparam int unsigned VW   = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [VW-1:0]     disp_q, disp_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  ssd_drive_t        out_q, out_d;

  logic              slot_end;
  logic              frame_end;
  logic [DIGITS-1:0] keep;
  logic              nz_seen;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              blank;
  logic [6:0]        dec_seg;

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Display takes shadow_d rather than shadow_q so a load on the frame-end
  // cycle is shown in the very next frame.
  always_comb begin
    shadow_d    = ssd_scan_load ? ssd_scan_value : shadow_q;
    shadow_dp_d = ssd_scan_load ? ssd_scan_dp_mask : shadow_dp_q;
    disp_d      = frame_end ? shadow_d : disp_q;
    disp_dp_d   = frame_end ? shadow_dp_d : disp_dp_q;
  end

  // keep[i] is set when any nibble from i up to the top is non-zero.
  always_comb begin
    keep    = '0;
    nz_seen = 1'b0;
    cur_nib = '0;
    cur_dp  = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz_seen = nz_seen | (disp_q[4*i +: 4] != 4'h0);
      keep[i] = nz_seen;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = disp_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
      end
    end
    blank = (BLANK_LZ != 0) && (idx_q != '0) && !keep[idx_q];
  end

  hex_to_ssd u_hex_to_ssd (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  // Blanked digits keep their anode so every slot has the same duty cycle.
  always_comb begin
    out_d     = SSD_DRIVE_OFF;
    out_d.seg = blank ? SSD_BLANK : dec_seg;
    out_d.dp  = ~cur_dp;
    if (ssd_scan_en) begin
      out_d.an[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst) begin
    if (!ssd_scan_rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      disp_q      <= '0;
      shadow_dp_q <= '0;
      disp_dp_q   <= '0;
      out_q       <= SSD_DRIVE_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      shadow_dp_q <= shadow_dp_d;
      disp_dp_q   <= disp_dp_d;
      out_q       <= out_d;
    end
  end

  assign ssd_scan_an    = out_q.an;
  assign ssd_scan_seg   = out_q.seg;
  assign ssd_scan_dp    = out_q.dp;
  assign ssd_scan_frame = frame_end;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: an 8-digit and a 4-digit instance checked every cycle
// against a cycle-count based model, plus decode vectors and corner sequences.
module tb_ssd_scan_mux;

  localparam int D  = 8;
  localparam int D4 = 4;
  localparam int R  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  dpm = '0;
  logic [15:0] value4 = '0;
  logic [3:0]  dpm4 = '0;

  logic [6:0] seg, seg4;
  logic       dp, dp4, frame, frame4;
  logic [7:0] an, an4;

  always #5 clk = ~clk;

  ssd_scan_mux #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_LZ(1)) dut (
    .ssd_scan_clk     (clk),
    .ssd_scan_rst     (rst_n),
    .ssd_scan_value   (value),
    .ssd_scan_load    (load),
    .ssd_scan_en      (en),
    .ssd_scan_dp_mask (dpm),
    .ssd_scan_seg     (seg),
    .ssd_scan_dp      (dp),
    .ssd_scan_an      (an),
    .ssd_scan_frame   (frame)
  );

  ssd_scan_mux #(.DIGITS(D4), .REFRESH_DIV(R), .BLANK_LZ(1)) dut4 (
    .ssd_scan_clk     (clk),
    .ssd_scan_rst     (rst_n),
    .ssd_scan_value   (value4),
    .ssd_scan_load    (load),
    .ssd_scan_en      (en),
    .ssd_scan_dp_mask (dpm4),
    .ssd_scan_seg     (seg4),
    .ssd_scan_dp      (dp4),
    .ssd_scan_an      (an4),
    .ssd_scan_frame   (frame4)
  );

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [16];

  // Model state: n counts clock edges since reset release.
  int          n;
  logic [31:0] m_shadow, m_disp;
  logic [7:0]  m_sdp, m_ddp;

  typedef struct {
    logic [31:0] val;
    logic [7:0]  mask;
    logic [6:0]  exp0;
    logic [6:0]  exp7;
    logic        exp_dp0;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t n=%0d)", name, act, exp, $time, n);
    end
  endtask

  function automatic int cur_idx(input int dd);
    return ((n - 1) / R) % dd;
  endfunction

  task automatic model_reset();
    n        = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_sdp    = '0;
    m_ddp    = '0;
  endtask

  // One clock: model the edge from the pre-edge state, then compare at negedge.
  task automatic tick();
    int          idx, idx4;
    logic [31:0] tail;
    logic [7:0]  e_an, e_an4;
    logic [6:0]  e_seg, e_seg4;
    logic        e_dp;
    @(posedge clk);
    n++;
    idx   = cur_idx(D);
    idx4  = cur_idx(D4);
    e_an  = en ? ~(8'h01 << idx) : 8'hFF;
    e_an4 = en ? ~(8'h01 << idx4) : 8'hFF;
    tail  = m_disp >> (4 * idx);
    e_seg = (idx != 0 && tail == 0) ? 7'h7F : seg_tab[tail[3:0]];
    e_dp  = ~m_ddp[idx];
    e_seg4 = (idx4 == 0) ? 7'h40 : 7'h7F;
    if (load) begin
      m_shadow = value;
      m_sdp    = dpm;
    end
    if (n % (R * D) == 0) begin
      m_disp = m_shadow;
      m_ddp  = m_sdp;
    end
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame", frame, ((n + 1) % (R * D)) == 0);
    chk("an4", an4, e_an4);
    chk("seg4", seg4, e_seg4);
    chk("dp4", dp4, 1'b1);
    chk("frame4", frame4, ((n + 1) % (R * D4)) == 0);
  endtask

  task automatic show_digit(input int d);
    for (int k = 0; k < 2 * R * D; k++) begin
      tick();
      if (cur_idx(D) == d) break;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_an"}, an, 8'hFF);
    chk({name, "_seg"}, seg, 7'h7F);
    chk({name, "_dp"}, dp, 1'b1);
    chk({name, "_frame"}, frame, 1'b0);
    chk({name, "_an4"}, an4, 8'hFF);
  endtask

  initial begin
    logic [31:0] v;
    logic        found;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++) begin
      vecs[i].val     = (32'(i) << 28) | 32'(i);
      vecs[i].mask    = (i % 2 == 1) ? 8'h01 : 8'h80;
      vecs[i].exp0    = seg_tab[i];
      vecs[i].exp7    = (i == 0) ? 7'h7F : seg_tab[i];
      vecs[i].exp_dp0 = (i % 2 == 1) ? 1'b0 : 1'b1;
    end
    model_reset();

    // Reset held.
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("rst_hold");
    end
    rst_n = 1'b1;

    // Free scan of zero display.
    repeat (70) tick();

    // Load mid-frame; display must wait for the frame boundary.
    value = 32'h0000_12AF;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = $urandom;
    repeat (40) tick();
    show_digit(3);
    chk("d3_after_load", seg, 7'h79);
    show_digit(5);
    chk("d5_blank", seg, 7'h7F);

    // Load exactly on the frame-end cycle.
    found = 1'b0;
    for (int k = 0; k < 2 * R * D && !found; k++) begin
      if (frame === 1'b1) found = 1'b1;
      else tick();
    end
    chk("frame_seen", found, 1'b1);
    value = 32'h0000_0001;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    value = $urandom;
    tick();
    chk("ld_on_frame_an", an, 8'hFE);
    chk("ld_on_frame_seg", seg, 7'h79);

    // Decimal point mask and enable gap.
    dpm   = 8'h04;
    value = 32'h0000_0001;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (45) tick();
    en = 1'b0;
    repeat (10) begin
      tick();
      chk("gap_an", an, 8'hFF);
    end
    en = 1'b1;
    repeat (40) tick();

    // Decode table through digit 0 and digit 7.
    foreach (vecs[i]) begin
      value = vecs[i].val;
      dpm   = vecs[i].mask;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      repeat (R * D) tick();
      show_digit(0);
      chk("vec_d0_seg", seg, vecs[i].exp0);
      chk("vec_d0_dp", dp, vecs[i].exp_dp0);
      show_digit(7);
      chk("vec_d7_seg", seg, vecs[i].exp7);
    end

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      v     = $urandom;
      value = v >> (4 * $urandom_range(0, 8));
      dpm   = 8'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 15) != 0);
      tick();
    end
    load = 1'b0;
    en   = 1'b1;

    // Asynchronous reset in the middle of digit 5's slot.
    value = 32'h8765_4321;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (R * D) tick();
    show_digit(5);
    tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("restart_an", an, 8'hFE);
    chk("restart_seg", seg, 7'h40);
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
